// File: rtl/assert_handshake_monitor.sv
// ---------------------------------------------------------------------------
// assert_handshake_monitor
//
// Watches a valid/ready handshake and flags protocol violations while a
// producer is stalled.  Three kinds of violation are reported:
//   1 : valid dropped before the transfer completed
//   2 : data changed while the producer was stalled
//   3 : the stall lasted TIMEOUT cycles with ready still low
//
// Ports
//   CLK              : clock; all state updates on the rising edge
//   ASYNCRESETN      : asynchronous reset, active low
//   en               : monitor enable; when low the FSM idles and nothing is checked
//   valid, ready     : monitored handshake
//   data[WIDTH]      : monitored payload
//   clr              : synchronous clear of the recorded error state
//   fail             : sticky flag, set by any violation since reset or clr
//   err_pulse        : one-cycle pulse for every detected violation
//   err_code[2]      : code of the last recorded violation (0 = none)
//   err_count[CNT]   : saturating count of recorded violations
//   cycle_count[CNT] : number of enabled cycles since reset, wrapping
//   first_fail_cycle : cycle_count value at the first recorded violation
// ---------------------------------------------------------------------------
module assert_handshake_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 en,
  input  logic                 valid,
  input  logic                 ready,
  input  logic [WIDTH-1:0]     data,
  input  logic                 clr,
  output logic                 fail,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] first_fail_cycle
);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_DROP    = 2'd1;
  localparam logic [1:0] CODE_CHANGE  = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] stall_cnt, stall_cnt_next;
  logic [WIDTH-1:0]     hold_data, hold_data_next;
  logic                 timeout_done, timeout_done_next;
  logic [1:0]           viol_code;

  // State register for the stall tracker.  timeout_done remembers that the
  // timeout of the current stall has already been reported, so it fires once.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state        <= IDLE;
      stall_cnt    <= '0;
      hold_data    <= '0;
      timeout_done <= 1'b0;
    end else begin
      state        <= state_next;
      stall_cnt    <= stall_cnt_next;
      hold_data    <= hold_data_next;
      timeout_done <= timeout_done_next;
    end
  end

  // Next-state logic.  A stall opens on valid without ready and closes on a
  // transfer or on valid dropping.  hold_data follows every data change so a
  // single change is reported only once.  stall_cnt saturates at TIMEOUT; a
  // timeout that loses to a higher-priority violation stays pending and is
  // reported on a later cycle of the same stall.
  always_comb begin
    state_next        = state;
    stall_cnt_next    = stall_cnt;
    hold_data_next    = hold_data;
    timeout_done_next = timeout_done;
    if (!en) begin
      state_next        = IDLE;
      stall_cnt_next    = '0;
      timeout_done_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && !ready) begin
            state_next        = STALL;
            stall_cnt_next    = CNT_ONE;
            hold_data_next    = data;
            timeout_done_next = 1'b0;
          end
        end
        STALL: begin
          if (!valid) begin
            state_next        = IDLE;
            stall_cnt_next    = '0;
            timeout_done_next = 1'b0;
          end else begin
            if (data != hold_data) begin
              hold_data_next = data;
            end
            if (viol_code == CODE_TIMEOUT) begin
              timeout_done_next = 1'b1;
            end
            if (ready) begin
              state_next        = IDLE;
              stall_cnt_next    = '0;
              timeout_done_next = 1'b0;
            end else if (stall_cnt != TIMEOUT_C) begin
              stall_cnt_next = stall_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Violation decode for the current sample, highest priority first:
  // dropped valid, then changed data, then timeout.
  always_comb begin
    viol_code = CODE_NONE;
    if (en && state == STALL) begin
      if (!valid) begin
        viol_code = CODE_DROP;
      end else if (data != hold_data) begin
        viol_code = CODE_CHANGE;
      end else if (!ready && stall_cnt == TIMEOUT_C && !timeout_done) begin
        viol_code = CODE_TIMEOUT;
      end
    end
  end

  // Registered reporting.  err_pulse always reflects the sampled violation,
  // even when clr wipes the recorded state in the same cycle.
  // first_fail_cycle takes the cycle_count value before this edge's increment.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      fail             <= 1'b0;
      err_pulse        <= 1'b0;
      err_code         <= CODE_NONE;
      err_count        <= '0;
      cycle_count      <= '0;
      first_fail_cycle <= '0;
    end else begin
      err_pulse <= (viol_code != CODE_NONE);
      if (en) begin
        cycle_count <= cycle_count + CNT_ONE;
      end
      if (clr) begin
        fail             <= 1'b0;
        err_code         <= CODE_NONE;
        err_count        <= '0;
        first_fail_cycle <= '0;
      end else if (viol_code != CODE_NONE) begin
        fail     <= 1'b1;
        err_code <= viol_code;
        if (err_count != CNT_MAX) begin
          err_count <= err_count + CNT_ONE;
        end
        if (!fail) begin
          first_fail_cycle <= cycle_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_assert_handshake_monitor.sv
// ---------------------------------------------------------------------------
// tb_assert_handshake_monitor
//
// Three monitor instances share one stimulus stream:
//   dut_a : defaults (CNT_WIDTH=16, TIMEOUT=15)
//   dut_b : CNT_WIDTH=4, TIMEOUT=15 (saturating counters)
//   dut_c : CNT_WIDTH=16, TIMEOUT=1
// A reference model per instance queues the expected outputs after every
// edge; a monitor process pops them on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_assert_handshake_monitor;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic       en, valid, ready, clr;
  logic [7:0] data;

  logic        fail_a, pulse_a;
  logic [1:0]  code_a;
  logic [15:0] count_a, cyc_a, first_a;
  logic        fail_b, pulse_b;
  logic [1:0]  code_b;
  logic [3:0]  count_b, cyc_b, first_b;
  logic        fail_c, pulse_c;
  logic [1:0]  code_c;
  logic [15:0] count_c, cyc_c, first_c;

  int n_compared = 0;
  int n_mismatch = 0;
  int n_en       = 0;

  // Abstract model state: prior counts stall samples without any bound.
  typedef struct {
    int stalling;
    int held;
    int prior;
    int to_done;
    int fail;
    int pulse;
    int code;
    int count;
    int cyc;
    int first;
  } mstate_t;

  mstate_t mdl [3];
  mstate_t q_a[$];
  mstate_t q_b[$];
  mstate_t q_c[$];
  int cfg_tmo [3] = '{15, 15, 1};
  int cfg_cw  [3] = '{16, 4, 16};

  assert_handshake_monitor #(.WIDTH(8), .CNT_WIDTH(16), .TIMEOUT(15)) dut_a (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .valid(valid), .ready(ready),
    .data(data), .clr(clr), .fail(fail_a), .err_pulse(pulse_a), .err_code(code_a),
    .err_count(count_a), .cycle_count(cyc_a), .first_fail_cycle(first_a)
  );

  assert_handshake_monitor #(.WIDTH(8), .CNT_WIDTH(4), .TIMEOUT(15)) dut_b (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .valid(valid), .ready(ready),
    .data(data), .clr(clr), .fail(fail_b), .err_pulse(pulse_b), .err_code(code_b),
    .err_count(count_b), .cycle_count(cyc_b), .first_fail_cycle(first_b)
  );

  assert_handshake_monitor #(.WIDTH(8), .CNT_WIDTH(16), .TIMEOUT(1)) dut_c (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .valid(valid), .ready(ready),
    .data(data), .clr(clr), .fail(fail_c), .err_pulse(pulse_c), .err_code(code_c),
    .err_count(count_c), .cycle_count(cyc_c), .first_fail_cycle(first_c)
  );

  always #5 CLK = ~CLK;

  // Reference behaviour for one sampled edge.
  function automatic mstate_t model_step(mstate_t s, bit rst_n, bit e, bit v, bit r,
                                         int d, bit c, int tmo, int cw);
    mstate_t n;
    int viol;
    int maxv;
    n    = s;
    viol = 0;
    maxv = (1 << cw) - 1;
    if (!rst_n) begin
      n = '{default: 0};
      return n;
    end
    if (!e) begin
      n.stalling = 0;
    end else begin
      if (s.stalling == 0) begin
        if (v && !r) begin
          n.stalling = 1;
          n.held     = d;
          n.prior    = 1;
          n.to_done  = 0;
        end
      end else if (!v) begin
        viol       = 1;
        n.stalling = 0;
      end else begin
        if (d != s.held) begin
          viol   = 2;
          n.held = d;
        end else if (!r && s.prior >= tmo && s.to_done == 0) begin
          viol      = 3;
          n.to_done = 1;
        end
        if (r) n.stalling = 0;
        else   n.prior    = s.prior + 1;
      end
      n.cyc = (s.cyc + 1) & maxv;
    end
    n.pulse = (viol != 0) ? 1 : 0;
    if (c) begin
      n.fail  = 0;
      n.code  = 0;
      n.count = 0;
      n.first = 0;
    end else if (viol != 0) begin
      n.fail = 1;
      n.code = viol;
      if (s.count < maxv) n.count = s.count + 1;
      if (s.fail == 0) n.first = s.cyc;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compareInst(input string tag, input mstate_t e, input logic [31:0] f,
                             input logic [31:0] p, input logic [31:0] cd,
                             input logic [31:0] cn, input logic [31:0] cy,
                             input logic [31:0] fi);
    checkOutput({tag, ".fail"},             f,  32'(e.fail));
    checkOutput({tag, ".err_pulse"},        p,  32'(e.pulse));
    checkOutput({tag, ".err_code"},         cd, 32'(e.code));
    checkOutput({tag, ".err_count"},        cn, 32'(e.count));
    checkOutput({tag, ".cycle_count"},      cy, 32'(e.cyc));
    checkOutput({tag, ".first_fail_cycle"}, fi, 32'(e.first));
  endtask

  // Drive one cycle of inputs, advance the models at the edge, queue results.
  task automatic applyStimulus(input bit e, input bit v, input bit r,
                               input logic [7:0] d, input bit c);
    en    = e;
    valid = v;
    ready = r;
    data  = d;
    clr   = c;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      mdl[i] = model_step(mdl[i], ASYNCRESETN, e, v, r, int'(d), c, cfg_tmo[i], cfg_cw[i]);
    end
    q_a.push_back(mdl[0]);
    q_b.push_back(mdl[1]);
    q_c.push_back(mdl[2]);
    if (!ASYNCRESETN) n_en = 0;
    else if (e) n_en++;
    #1;
  endtask

  // Scoreboard monitor: outputs are presented every cycle, compared mid-cycle.
  initial begin
    mstate_t e;
    forever begin
      @(negedge CLK);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        compareInst("sb.a", e, 32'(fail_a), 32'(pulse_a), 32'(code_a), 32'(count_a),
                    32'(cyc_a), 32'(first_a));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        compareInst("sb.b", e, 32'(fail_b), 32'(pulse_b), 32'(code_b), 32'(count_b),
                    32'(cyc_b), 32'(first_b));
      end
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        compareInst("sb.c", e, 32'(fail_c), 32'(pulse_c), 32'(code_c), 32'(count_c),
                    32'(cyc_c), 32'(first_c));
      end
    end
  end

  initial begin
    mstate_t zero;
    int exp_first;
    int pulses_a, pulses_b, pulses_c;
    int idx_a, idx_b, idx_c;
    logic [7:0] d;

    zero = '{default: 0};
    for (int i = 0; i < 3; i++) mdl[i] = zero;
    ASYNCRESETN = 1'b0;
    en = 1'b0; valid = 1'b0; ready = 1'b0; clr = 1'b0; data = 8'h00;

    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h12, 1'b0);
    checkOutput("reset.fail", 32'(fail_a), 32'd0);
    checkOutput("reset.err_count", 32'(count_a), 32'd0);
    checkOutput("reset.cycle_count", 32'(cyc_a), 32'd0);
    ASYNCRESETN = 1'b1;

    // Stall on 0x5A for three cycles, then a clean transfer
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    checkOutput("clean.err_pulse", 32'(pulse_a), 32'd0);
    checkOutput("clean.fail", 32'(fail_a), 32'd0);
    checkOutput("clean.err_count", 32'(count_a), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Valid dropped mid-stall
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
    exp_first = n_en;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
    checkOutput("drop.err_pulse", 32'(pulse_a), 32'd1);
    checkOutput("drop.err_code", 32'(code_a), 32'd1);
    checkOutput("drop.err_count", 32'(count_a), 32'd1);
    checkOutput("drop.fail", 32'(fail_a), 32'd1);
    checkOutput("drop.first_fail_cycle", 32'(first_a), 32'(exp_first));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("drop.pulse_once", 32'(pulse_a), 32'd0);

    // Clear, then data changes 0x5A -> 0x5B -> 0x5C while stalled
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("clr.fail", 32'(fail_a), 32'd0);
    checkOutput("clr.err_count", 32'(count_a), 32'd0);
    checkOutput("clr.first_fail_cycle", 32'(first_a), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
    exp_first = n_en;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5B, 1'b0);
    checkOutput("chg1.err_pulse", 32'(pulse_a), 32'd1);
    checkOutput("chg1.err_code", 32'(code_a), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5C, 1'b0);
    checkOutput("chg2.err_pulse", 32'(pulse_a), 32'd1);
    checkOutput("chg2.err_code", 32'(code_a), 32'd2);
    checkOutput("chg2.err_count", 32'(count_a), 32'd2);
    checkOutput("chg2.first_fail_cycle", 32'(first_a), 32'(exp_first));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5C, 1'b0);
    checkOutput("chg.transfer_quiet", 32'(pulse_a), 32'd0);

    // Stall held for 20 samples: a single timeout pulse per instance
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    pulses_a = 0; pulses_b = 0; pulses_c = 0;
    idx_a = -1; idx_b = -1; idx_c = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
      if (pulse_a) begin pulses_a++; if (idx_a < 0) idx_a = k; end
      if (pulse_b) begin pulses_b++; if (idx_b < 0) idx_b = k; end
      if (pulse_c) begin pulses_c++; if (idx_c < 0) idx_c = k; end
    end
    checkOutput("tmo.a.pulses", 32'(pulses_a), 32'd1);
    checkOutput("tmo.a.index", 32'(idx_a), 32'd15);
    checkOutput("tmo.a.err_code", 32'(code_a), 32'd3);
    checkOutput("tmo.b.pulses", 32'(pulses_b), 32'd1);
    checkOutput("tmo.c.pulses", 32'(pulses_c), 32'd1);
    checkOutput("tmo.c.index", 32'(idx_c), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h33, 1'b0);

    // Twenty data changes saturate the 4-bit counter; then clr with a violation
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 20; k++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(k), 1'b0);
    checkOutput("sat.b.err_count", 32'(count_b), 32'd15);
    checkOutput("sat.a.err_count", 32'(count_a), 32'd20);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd21, 1'b0);
    checkOutput("sat.b.pulse", 32'(pulse_b), 32'd1);
    checkOutput("sat.b.held", 32'(count_b), 32'd15);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd22, 1'b1);
    checkOutput("clrviol.b.err_pulse", 32'(pulse_b), 32'd1);
    checkOutput("clrviol.b.fail", 32'(fail_b), 32'd0);
    checkOutput("clrviol.b.err_count", 32'(count_b), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd22, 1'b0);

    // Asynchronous reset between edges in the middle of a stall
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5B, 1'b0);
    @(negedge CLK);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    compareInst("arst.a", zero, 32'(fail_a), 32'(pulse_a), 32'(code_a), 32'(count_a),
                32'(cyc_a), 32'(first_a));
    compareInst("arst.b", zero, 32'(fail_b), 32'(pulse_b), 32'(code_b), 32'(count_b),
                32'(cyc_b), 32'(first_b));
    compareInst("arst.c", zero, 32'(fail_c), 32'(pulse_c), 32'(code_c), 32'(count_c),
                32'(cyc_c), 32'(first_c));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5B, 1'b0);
    ASYNCRESETN = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
    checkOutput("arst.after.err_pulse", 32'(pulse_a), 32'd0);
    checkOutput("arst.after.fail", 32'(fail_a), 32'd0);
    checkOutput("arst.after.cycle_count", 32'(cyc_a), 32'd1);

    // Randomized traffic
    d = 8'h5A;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) d = 8'($urandom_range(0, 255));
      applyStimulus($urandom_range(0, 15) != 0,
                    $urandom_range(0, 5) != 0,
                    (k < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
                    d,
                    $urandom_range(0, 63) == 0);
    end

    // Let the monitor drain its queues, bounded
    for (int k = 0; k < 5 && (q_a.size() + q_b.size() + q_c.size()) != 0; k++) begin
      @(negedge CLK);
      #1;
    end
    checkOutput("drain.pending", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
